// File: rtl/tally_uart_tx.sv
// -----------------------------------------------------------------------------
// tally_uart_tx
//
// Purpose:
//   Result-mode readout transmitter. When a send is accepted, it takes a
//   snapshot of the four candidate tallies and their 8-bit checksum. It then
//   serialises a fixed 6-byte UART packet: A5, cand1..cand4, checksum. Each
//   byte is framed 8N1, LSB first, and bytes follow each other with no idle
//   gap.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports:
//   clock        system clock, rising edge active
//   reset        asynchronous active-low reset
//   mode         0 = voting mode, 1 = result mode (send accepted only when 1)
//   send         request, level-sampled on each rising edge
//   cand1_vote   candidate 1 tally
//   cand2_vote   candidate 2 tally
//   cand3_vote   candidate 3 tally
//   cand4_vote   candidate 4 (authority) tally
//   tx           UART serial line, idles high (registered)
//   busy         high while a packet is in flight (registered)
//   done         one-cycle pulse when a packet completes (registered)
// -----------------------------------------------------------------------------
module tally_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       send,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_byte_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_c1;
  logic [7:0]       r_c2;
  logic [7:0]       r_c3;
  logic [7:0]       r_c4;
  logic [7:0]       r_sum;

  logic [9:0]       w_sum10;
  logic             w_bit_end;
  logic [7:0]       w_cur_byte;

  // Sum is formed in 10 bits; only the low byte is kept, so overflow wraps.
  assign w_sum10 = {2'b00, cand1_vote} + {2'b00, cand2_vote}
                 + {2'b00, cand3_vote} + {2'b00, cand4_vote};

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Byte currently being framed, taken from the snapshot only.
  always_comb begin
    w_cur_byte = 8'h00;
    case (r_byte_idx)
      3'd0:    w_cur_byte = HEADER;
      3'd1:    w_cur_byte = r_c1;
      3'd2:    w_cur_byte = r_c2;
      3'd3:    w_cur_byte = r_c3;
      3'd4:    w_cur_byte = r_c4;
      3'd5:    w_cur_byte = r_sum;
      default: w_cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_c3       <= '0;
      r_c4       <= '0;
      r_sum      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (send && mode) begin
            // Start bit goes out on the accepting edge itself.
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_c1       <= cand1_vote;
            r_c2       <= cand2_vote;
            r_c3       <= cand3_vote;
            r_c4       <= cand4_vote;
            r_sum      <= w_sum10[7:0];
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            tx        <= w_cur_byte[0];
            r_shift   <= {1'b0, w_cur_byte[7:1]};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              tx      <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              tx        <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_byte_idx == 3'd5) begin
              r_state    <= S_IDLE;
              r_byte_idx <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              tx         <= 1'b1;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              r_byte_idx <= r_byte_idx + 3'd1;
              r_state    <= S_START;
              tx         <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tally_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_tally_uart_tx
//
// Purpose:
//   Self-checking bench for tally_uart_tx with CLKS_PER_BIT = 4. A table of
//   tally vectors with hand-computed checksums drives full packets, which are
//   decoded from the tx line and compared. Hand-written sequences cover reset,
//   snapshot, mode gating, send-while-busy, mid-packet reset and back-to-back
//   operation.
// -----------------------------------------------------------------------------
module tb_tally_uart_tx;

  localparam int CPB = 4;
  localparam int PKT = 60 * CPB;   // 240 cycles
  localparam int HIST = 600;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       send;
  logic [7:0] cand1_vote;
  logic [7:0] cand2_vote;
  logic [7:0] cand3_vote;
  logic [7:0] cand4_vote;
  logic       tx;
  logic       busy;
  logic       done;

  tally_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .send       (send),
    .cand1_vote (cand1_vote),
    .cand2_vote (cand2_vote),
    .cand3_vote (cand3_vote),
    .cand4_vote (cand4_vote),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
    logic [7:0] c4;
    logic [7:0] sum;   // hand-computed (c1+c2+c3+c4) mod 256
  } vec_t;

  vec_t vecs[6];

  int   n_vec;
  int   n_err;
  logic tx_h   [HIST];
  logic busy_h [HIST];
  logic done_h [HIST];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  // Sample at each negedge after E0+k; drive send/cand1 for the next edge.
  task automatic capture(input int n, input int hold_k, input int send_k,
                         input int chg_k, input logic [7:0] chg_v);
    for (int k = 0; k < n; k++) begin
      tx_h[k]   = tx;
      busy_h[k] = busy;
      done_h[k] = done;
      send = (k < hold_k) || (k == send_k);
      if (k == chg_k) cand1_vote = chg_v;
      @(negedge clock);
    end
    send = 1'b0;
  endtask

  // Raise send for one edge (E0) and return at the negedge following E0.
  task automatic start_send();
    send = 1'b1;
    @(negedge clock);
  endtask

  task automatic set_cands(input vec_t v);
    cand1_vote = v.c1;
    cand2_vote = v.c2;
    cand3_vote = v.c3;
    cand4_vote = v.c4;
  endtask

  function automatic int count_ones(input int first, input int last, input int which);
    int c;
    c = 0;
    for (int k = first; k <= last; k++) begin
      if (which == 0 && tx_h[k] === 1'b1)   c++;
      if (which == 1 && busy_h[k] === 1'b1) c++;
      if (which == 2 && done_h[k] === 1'b1) c++;
    end
    return c;
  endfunction

  // Decode a 6-byte packet starting at history index base (start of byte 0).
  task automatic check_packet(input int base, input logic [5:0][7:0] exp, input string tag);
    logic [7:0] b;
    int         frame_ok;
    frame_ok = 1;
    for (int j = 0; j < 6; j++) begin
      if (tx_h[base + j*10*CPB + 2] !== 1'b0)     frame_ok = 0;
      if (tx_h[base + (j*10+9)*CPB + 2] !== 1'b1) frame_ok = 0;
      for (int bi = 0; bi < 8; bi++)
        b[bi] = tx_h[base + (j*10 + 1 + bi)*CPB + 2];
      chk($sformatf("%s byte%0d", tag, j), int'(b), int'(exp[j]));
    end
    chk($sformatf("%s framing", tag), frame_ok, 1);
  endtask

  function automatic logic [5:0][7:0] pkt_of(input vec_t v);
    return {v.sum, v.c4, v.c3, v.c2, v.c1, 8'hA5};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{c1: 8'd3,   c2: 8'd7,   c3: 8'd0,   c4: 8'd255, sum: 8'h09};
    vecs[1] = '{c1: 8'd200, c2: 8'd100, c3: 8'd0,   c4: 8'd0,   sum: 8'h2C};
    vecs[2] = '{c1: 8'd0,   c2: 8'd0,   c3: 8'd0,   c4: 8'd0,   sum: 8'h00};
    vecs[3] = '{c1: 8'd255, c2: 8'd255, c3: 8'd255, c4: 8'd255, sum: 8'hFC};
    vecs[4] = '{c1: 8'd1,   c2: 8'd2,   c3: 8'd3,   c4: 8'd4,   sum: 8'h0A};
    vecs[5] = '{c1: 8'd128, c2: 8'd128, c3: 8'd17,  c4: 8'd0,   sum: 8'h11};

    reset = 1'b0;
    mode  = 1'b0;
    send  = 1'b0;
    set_cands(vecs[0]);

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b1;
    @(negedge clock);
    mode = 1'b1;

    // Table-driven packets
    for (int i = 0; i < 6; i++) begin
      set_cands(vecs[i]);
      start_send();
      capture(PKT + 5, 0, -1, -1, 8'h00);
      check_packet(0, pkt_of(vecs[i]), $sformatf("vec%0d", i));
      chk($sformatf("vec%0d start latency", i), int'(tx_h[0]), 0);
      chk($sformatf("vec%0d busy cycles", i), count_ones(0, PKT + 4, 1), PKT);
      chk($sformatf("vec%0d done at E0+240", i), int'(done_h[PKT]), 1);
      chk($sformatf("vec%0d done pulses", i), count_ones(0, PKT + 4, 2), 1);
      chk($sformatf("vec%0d idle after", i), count_ones(PKT, PKT + 4, 0), 5);
    end

    // Snapshot: cand1 changes during byte 1
    set_cands(vecs[0]);
    start_send();
    capture(PKT + 5, 0, -1, 45, 8'd4);
    check_packet(0, pkt_of(vecs[0]), "snapshot");
    cand1_vote = 8'd3;

    // Mode gating: send with mode = 0
    mode = 1'b0;
    start_send();
    capture(300, 0, -1, -1, 8'd3);
    chk("mode0 tx high cycles", count_ones(0, 299, 0), 300);
    chk("mode0 busy cycles", count_ones(0, 299, 1), 0);
    mode = 1'b1;

    // Send while busy is dropped
    start_send();
    capture(300, 0, 100, -1, 8'd3);
    check_packet(0, pkt_of(vecs[0]), "busy-send");
    chk("busy-send busy cycles", count_ones(0, 299, 1), PKT);
    chk("busy-send done pulses", count_ones(0, 299, 2), 1);

    // Reset during byte 2, bit 3 (cycles 96..99 of the packet)
    start_send();
    capture(97, 0, -1, -1, 8'd3);
    chk("pre-reset tx (byte2 bit3)", int'(tx), 0);
    chk("pre-reset busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async reset tx", int'(tx), 1);
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    set_cands(vecs[4]);
    start_send();
    capture(PKT + 5, 0, -1, -1, 8'd1);
    check_packet(0, pkt_of(vecs[4]), "post-reset");
    chk("post-reset busy cycles", count_ones(0, PKT + 4, 1), PKT);

    // Back-to-back with send held high
    set_cands(vecs[1]);
    start_send();
    capture(2*PKT + 5, 300, -1, -1, 8'd200);
    check_packet(0, pkt_of(vecs[1]), "b2b pkt1");
    check_packet(PKT + 1, pkt_of(vecs[1]), "b2b pkt2");
    chk("b2b done at E0+240", int'(done_h[PKT]), 1);
    chk("b2b second start bit", int'(tx_h[PKT + 1]), 0);
    chk("b2b busy re-asserted", int'(busy_h[PKT + 1]), 1);
    chk("b2b busy cycles", count_ones(0, 2*PKT + 4, 1), 2*PKT);
    chk("b2b done pulses", count_ones(0, 2*PKT + 4, 2), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
